// File: rtl/SerialAddSubPkg.sv
// Shared definitions for the bit-serial adder/subtractor:
// control FSM state encoding and operation select codes.
package SerialAddSubPkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/FullAdder_GL.sv
// Gate-level single-bit full adder, used as the
// arithmetic slice of the serial adder/subtractor.
module FullAdder_GL (
   input  logic in0,
   input  logic in1,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic p;

   assign p    = in0 ^ in1;
   assign sum  = p ^ cin;
   assign cout = (in0 & in1) | (p & cin);

endmodule

// File: rtl/serial_add_sub_rtl.sv
// Bit-serial add/sub: one full-adder slice, nbits cycles per op,
// val/rdy operand and result streams.
module serial_add_sub_rtl
   import SerialAddSubPkg::*;
#(
   parameter int nbits = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             istream_val,
   output logic             istream_rdy,
   input  logic             op,
   input  logic [nbits-1:0] in0,
   input  logic [nbits-1:0] in1,
   output logic             ostream_val,
   input  logic             ostream_rdy,
   output logic [nbits-1:0] result,
   output logic             cout
);

   localparam int cw = $clog2(nbits) + 1;
   localparam logic [cw-1:0] last = cw'(nbits - 1);

   state_t state;
   state_t state_next;

   logic [nbits-1:0] a;
   logic [nbits-1:0] b;
   logic [nbits-1:0] res;
   logic             carry;
   logic [cw-1:0]    cnt;

   logic             sum;
   logic             carry_out;
   logic             accept;
   logic             step;
   logic [nbits:0]   res_shift;

   FullAdder_GL fa (
      .in0  (a[0]),
      .in1  (b[0]),
      .cin  (carry),
      .sum  (sum),
      .cout (carry_out)
   );

   // Sum bit enters at the MSB so the LSB-first result lands aligned.
   assign res_shift = {sum, res};

   always_comb begin
      state_next  = state;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      accept      = 1'b0;
      step        = 1'b0;
      unique case (state)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (cnt == last)
               state_next = DONE;
         end
         DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: the +1 comes from the carry seed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            a     <= in0;
            b     <= (op == OP_SUB) ? ~in1 : in1;
            carry <= op;
            cnt   <= '0;
         end else if (step) begin
            a     <= a >> 1;
            b     <= b >> 1;
            res   <= res_shift[nbits:1];
            carry <= carry_out;
            cnt   <= cnt + 1'b1;
         end
      end
   end

   assign result = res;
   assign cout   = carry;

endmodule

// File: doc/serial_add_sub_rtl.md
# serial_add_sub_rtl

Multi-cycle, bit-serial adder/subtractor. Computes `in0 + in1` or `in0 - in1` over `nbits` cycles using a single full-adder bit slice and a carry/borrow flop. Accepts operands on a val/rdy input stream and returns the result on a val/rdy output stream. It is the subtraction-capable, sequential companion to the combinational full adder, and serves as the low-area ALU option for the TinyRV1 datapath.

## Interface

Parameters:
- `nbits`, 8 — operand and result width; legal range 1..32.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low. `reset`=0 immediately forces the reset state.
- `istream_val`  in  1  — operands valid.
- `istream_rdy`  out  1  — block can accept operands.
- `op`  in  1  — 0 = add, 1 = subtract. Sampled with the operands.
- `in0`  in  `nbits`  — first operand, unsigned.
- `in1`  in  `nbits`  — second operand, unsigned.
- `ostream_val`  out  1  — result valid.
- `ostream_rdy`  in  1  — consumer can take the result.
- `result`  out  `nbits`  — sum or difference, modulo 2^`nbits`.
- `cout`  out  1  — add: carry out. Subtract: 1 means no borrow (`in0` ≥ `in1`); 0 means borrow.

## Operation

- States (encoded in the package): IDLE, CALC, DONE.
- **IDLE**
  - `istream_rdy`=1, `ostream_val`=0.
  - On `istream_val`&`istream_rdy`, latch `in0` into shift register A.
  - Latch `in1` into shift register B; if `op`=1, latch `~in1` instead.
  - Set the carry flop to `op`, clear the bit counter, latch `op`, go to CALC.
- **CALC**
  - `istream_rdy`=0, `ostream_val`=0.
  - Each cycle, the full-adder slice takes A[0], B[0] and carry.
  - The sum bit shifts into the MSB of the result register, which shifts right.
  - A and B shift right; carry takes the slice's carry out; the counter increments.
  - After the `nbits`-th bit, go to DONE.
- **DONE**
  - `ostream_val`=1; `result` and `cout` are held stable.
  - On `ostream_val`&`ostream_rdy`, go to IDLE.
  - `istream_rdy` stays 0 in DONE. Input and output handshakes never fire in the same cycle.
- Result and `cout` are exact two's-complement add/sub, modulo 2^`nbits`.
- Operand inputs are ignored outside the IDLE accept cycle. Changing them during CALC has no effect.
- Reset mid-operation:
  - The operation is aborted and no result is produced.
  - State goes to IDLE; the result register, `cout`, shift registers and counter clear to 0.

## Timing

- Reset values: `istream_rdy`=1, `ostream_val`=0, `result`=0, `cout`=0.
- `istream_rdy` and `ostream_val` are decoded from state only, with no combinational path from inputs.
- Latency, with input accepted at edge E0:
  - CALC occupies the cycles after E0 through edge E`nbits`.
  - `ostream_val` rises after edge E`nbits`.
  - Minimum input-to-output latency is `nbits` cycles.
- Throughput is one operation per `nbits`+2 cycles when `ostream_rdy` is held at 1. This includes the IDLE accept cycle after the output handshake.
- `nbits`=1: CALC lasts exactly one cycle.
- The bit counter is `$clog2(nbits)+1` bits wide.
- Backpressure: DONE holds indefinitely while `ostream_rdy`=0, and outputs do not change.

## Structure

- Package `SerialAddSubPkg`:
  - state enum (IDLE, CALC, DONE);
  - `OP_ADD`=0 and `OP_SUB`=1 constants.
- The bit slice is an instance of the existing `FullAdder_GL`, not re-coded inline.
- Control FSM and datapath registers live in the top module. No other sub-modules.

## Test plan

All cases use `nbits`=8 and check the full handshake timing.

- **Add, no carry:** 5 + 3 → `result`=0x08, `cout`=0; `ostream_val` rises exactly 8 cycles after acceptance.
- **Subtract, no borrow:** 5 − 3 → `result`=0x02, `cout`=1.
- **Subtract, borrow:** 3 − 5 → `result`=0xFE, `cout`=0.
- **Add, overflow:** 200 + 100 → `result`=0x2C, `cout`=1. Also 0xFF + 0x01 → 0x00, `cout`=1.
- **Backpressure and input stall:**
  - Hold `ostream_rdy`=0 for 3 cycles in DONE → `result` stable throughout.
  - `istream_rdy`=0 during CALC and DONE; a new `istream_val` there is not accepted.
  - After the output handshake, back-to-back operations are accepted.
- **Reset mid-CALC:**
  - Assert `reset`=0 for one cycle in CALC → outputs immediately return to reset values and no result is produced.
  - The next operation, 0x80 − 0x01, gives 0x7F with `cout`=1.
